multi_timer_control: RTL and testbench

- Parametrised successor to the egg-timer main controller.
- Runs N_CH independent cook-timer channels, each with its own state machine (idle/program/load/run/pause/done).
- Adds pause/resume, channel selection, and a bounded blinking alarm with acknowledge.
- Sits between the debounced button/switch front end and the per-channel setting counters and countdown timers.

---
 rtl/timer_ctrl_pkg.sv | 28 ++
 rtl/timer_channel_fsm.sv | 115 +++++++++++
 rtl/multi_timer_control.sv | 81 ++++++++
 tb/tb_multi_timer_control.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the multi-channel cook-timer controller:
// channel state encoding and the alarm counter width helper.
package timer_ctrl_pkg;

    // Per-channel state codes; 6 and 7 are unused and recover to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROG  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Bits needed to hold values 0..(value-1), never less than one.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/timer_channel_fsm.sv
// One cook-timer channel: state register, next-state logic, bounded
// alarm counter and Moore output decode. Commands arrive already
// un-qualified; i_sel gates them here.
module timer_channel_fsm
    import timer_ctrl_pkg::*;
#(
    parameter int ALARM_PULSES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sel,
    input  logic i_cooktime_req,
    input  logic i_start_req,
    input  logic i_pause_req,
    input  logic i_alarm_ack,
    input  logic i_timer_done,
    input  logic i_led_pulse,
    input  logic i_other_enters_prog,
    output logic o_enters_prog,
    output logic o_prog,
    output logic o_load,
    output logic o_run,
    output logic o_alarm
);

    localparam int             CNT_W      = clog2_min1(ALARM_PULSES + 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_PULSES);

    state_t           r_state;
    state_t           w_next_base;
    state_t           w_next;
    logic [CNT_W-1:0] r_alarm_cnt;

    logic w_cook;
    logic w_start;
    logic w_pause;
    logic w_ack;

    assign w_cook  = i_sel & i_cooktime_req;
    assign w_start = i_sel & i_start_req;
    assign w_pause = i_sel & i_pause_req;
    assign w_ack   = i_sel & i_alarm_ack;

    // Own next state from this channel's commands, ignoring other channels.
    always_comb begin
        // NOTE: every path starts from a default so no latch is inferred.
        w_next_base = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cook)       w_next_base = ST_PROG;
                else if (w_start) w_next_base = ST_LOAD;
            end
            ST_PROG: begin
                if (w_start)      w_next_base = ST_LOAD;
            end
            ST_LOAD: begin
                w_next_base = ST_RUN;
            end
            ST_RUN: begin
                if (w_cook)            w_next_base = ST_PROG;
                else if (i_timer_done) w_next_base = ST_DONE;
                else if (w_pause)      w_next_base = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_cook)                  w_next_base = ST_PROG;
                else if (w_start || w_pause) w_next_base = ST_RUN;
            end
            ST_DONE: begin
                if (w_cook)       w_next_base = ST_PROG;
                else if (w_start) w_next_base = ST_LOAD;
                else if (w_ack)   w_next_base = ST_IDLE;
            end
            default: begin
                w_next_base = ST_IDLE;
            end
        endcase
    end

    // Kept independent of i_other_enters_prog so the cross-channel wiring has no loop.
    assign o_enters_prog = (w_next_base == ST_PROG) && (r_state != ST_PROG);

    // Yield the editor role when another channel starts programming.
    always_comb begin
        w_next = w_next_base;
        if ((r_state == ST_PROG) && i_other_enters_prog) begin
            w_next = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Alarm flash budget: loaded on entering DONE, counts led_pulse down, cleared on exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alarm_cnt <= '0;
        end else if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
            r_alarm_cnt <= ALARM_LOAD;
        end else if (w_next != ST_DONE) begin
            r_alarm_cnt <= '0;
        end else if (i_led_pulse && (r_alarm_cnt != '0)) begin
            r_alarm_cnt <= r_alarm_cnt - CNT_W'(1);
        end
    end

    assign o_prog  = (r_state == ST_PROG);
    assign o_load  = (r_state == ST_LOAD);
    assign o_run   = (r_state == ST_RUN);
    assign o_alarm = (r_state == ST_DONE) && ((ALARM_PULSES == 0) || (r_alarm_cnt != '0));

endmodule

// File: rtl/multi_timer_control.sv
// Multi-channel cook-timer main controller. Holds the shared blink
// register, decodes ch_sel, enforces a single programming channel and
// combines the per-channel alarms.
module multi_timer_control #(
    parameter int N_CH         = 2,
    parameter int SEL_W        = 1,
    parameter int ALARM_PULSES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             led_pulse,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic             cooktime_req,
    input  logic             start_req,
    input  logic             pause_req,
    input  logic             alarm_ack,
    input  logic             seconds_req,
    input  logic             minutes_req,
    input  logic [N_CH-1:0]  timer_done,
    output logic [N_CH-1:0]  increment_seconds,
    output logic [N_CH-1:0]  increment_minutes,
    output logic [N_CH-1:0]  prog_mode,
    output logic [N_CH-1:0]  load_timer,
    output logic [N_CH-1:0]  run_enable,
    output logic [N_CH-1:0]  enabled_led,
    output logic [N_CH-1:0]  running_led,
    output logic [N_CH-1:0]  alarm_vec,
    output logic             alarm_out
);

    logic            r_flash;
    logic [N_CH-1:0] w_sel;
    logic [N_CH-1:0] w_enters_prog;
    logic [N_CH-1:0] w_other_enters_prog;
    logic [N_CH-1:0] w_prog;
    logic [N_CH-1:0] w_load;
    logic [N_CH-1:0] w_run;
    logic [N_CH-1:0] w_alarm;

    // Shared blink phase: toggles on each led_pulse strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_flash <= 1'b0;
        else if (led_pulse) r_flash <= ~r_flash;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_sel[i]               = (int'(ch_sel) == i);
        assign w_other_enters_prog[i] = |(w_enters_prog & ~(N_CH'(1) << i));

        timer_channel_fsm #(
            .ALARM_PULSES(ALARM_PULSES)
        ) u_channel (
            .clk                (clk),
            .reset_n            (reset_n),
            .i_sel              (w_sel[i]),
            .i_cooktime_req     (cooktime_req),
            .i_start_req        (start_req),
            .i_pause_req        (pause_req),
            .i_alarm_ack        (alarm_ack),
            .i_timer_done       (timer_done[i]),
            .i_led_pulse        (led_pulse),
            .i_other_enters_prog(w_other_enters_prog[i]),
            .o_enters_prog      (w_enters_prog[i]),
            .o_prog             (w_prog[i]),
            .o_load             (w_load[i]),
            .o_run              (w_run[i]),
            .o_alarm            (w_alarm[i])
        );
    end

    assign increment_seconds = w_prog & w_sel & {N_CH{cooktime_req & seconds_req}};
    assign increment_minutes = w_prog & w_sel & {N_CH{cooktime_req & minutes_req}};
    assign prog_mode         = w_prog;
    assign load_timer        = w_load;
    assign run_enable        = w_run;
    assign enabled_led       = w_run;
    assign running_led       = w_run & {N_CH{r_flash}};
    assign alarm_vec         = w_alarm;
    assign alarm_out         = (|w_alarm) & r_flash;

endmodule

// File: tb/tb_multi_timer_control.sv
// Self-checking bench for multi_timer_control: directed scenarios with
// literal expectations, then randomized traffic compared every cycle
// against a behavioural model of the channel rules.
module tb_multi_timer_control;

    localparam int N_CH         = 2;
    localparam int SEL_W        = 2;
    localparam int ALARM_PULSES = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             led_pulse;
    logic [SEL_W-1:0] ch_sel;
    logic             cooktime_req;
    logic             start_req;
    logic             pause_req;
    logic             alarm_ack;
    logic             seconds_req;
    logic             minutes_req;
    logic [N_CH-1:0]  timer_done;
    logic [N_CH-1:0]  increment_seconds;
    logic [N_CH-1:0]  increment_minutes;
    logic [N_CH-1:0]  prog_mode;
    logic [N_CH-1:0]  load_timer;
    logic [N_CH-1:0]  run_enable;
    logic [N_CH-1:0]  enabled_led;
    logic [N_CH-1:0]  running_led;
    logic [N_CH-1:0]  alarm_vec;
    logic             alarm_out;

    always #5 clk = ~clk;

    multi_timer_control #(
        .N_CH        (N_CH),
        .SEL_W       (SEL_W),
        .ALARM_PULSES(ALARM_PULSES)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .led_pulse        (led_pulse),
        .ch_sel           (ch_sel),
        .cooktime_req     (cooktime_req),
        .start_req        (start_req),
        .pause_req        (pause_req),
        .alarm_ack        (alarm_ack),
        .seconds_req      (seconds_req),
        .minutes_req      (minutes_req),
        .timer_done       (timer_done),
        .increment_seconds(increment_seconds),
        .increment_minutes(increment_minutes),
        .prog_mode        (prog_mode),
        .load_timer       (load_timer),
        .run_enable       (run_enable),
        .enabled_led      (enabled_led),
        .running_led      (running_led),
        .alarm_vec        (alarm_vec),
        .alarm_out        (alarm_out)
    );

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_PROG, M_LOAD, M_RUN, M_PAUSE, M_DONE} mstate_t;

    mstate_t m_st  [N_CH];
    int      m_rem [N_CH];
    bit      m_flash;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_st[i]  = M_IDLE;
            m_rem[i] = 0;
        end
        m_flash = 1'b0;
    endtask

    task automatic model_step();
        mstate_t nx [N_CH];
        int      entrant;
        bit      sel, cook, start, pause, ack;
        entrant = -1;
        for (int i = 0; i < N_CH; i++) begin
            sel   = (int'(ch_sel) == i);
            cook  = sel && cooktime_req;
            start = sel && start_req;
            pause = sel && pause_req;
            ack   = sel && alarm_ack;
            nx[i] = m_st[i];
            case (m_st[i])
                M_IDLE:  nx[i] = cook ? M_PROG : (start ? M_LOAD : M_IDLE);
                M_PROG:  nx[i] = start ? M_LOAD : M_PROG;
                M_LOAD:  nx[i] = M_RUN;
                M_RUN:   nx[i] = cook ? M_PROG : (timer_done[i] ? M_DONE : (pause ? M_PAUSE : M_RUN));
                M_PAUSE: nx[i] = cook ? M_PROG : ((start || pause) ? M_RUN : M_PAUSE);
                M_DONE:  nx[i] = cook ? M_PROG : (start ? M_LOAD : (ack ? M_IDLE : M_DONE));
                default: nx[i] = M_IDLE;
            endcase
            if (nx[i] == M_PROG && m_st[i] != M_PROG) entrant = i;
        end
        for (int j = 0; j < N_CH; j++) begin
            if (entrant >= 0 && j != entrant && m_st[j] == M_PROG) nx[j] = M_IDLE;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (nx[i] == M_DONE && m_st[i] != M_DONE)   m_rem[i] = ALARM_PULSES;
            else if (nx[i] != M_DONE)                   m_rem[i] = 0;
            else if (led_pulse && m_rem[i] > 0)         m_rem[i] = m_rem[i] - 1;
            m_st[i] = nx[i];
        end
        if (led_pulse) m_flash = !m_flash;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    function automatic logic [N_CH-1:0] exp_in(input mstate_t s);
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = (m_st[i] == s);
        return v;
    endfunction

    function automatic logic [N_CH-1:0] exp_alarm();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = (m_st[i] == M_DONE) && (ALARM_PULSES == 0 || m_rem[i] > 0);
        return v;
    endfunction

    function automatic logic [N_CH-1:0] exp_inc(input logic req);
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++)
            v[i] = (m_st[i] == M_PROG) && (int'(ch_sel) == i) && cooktime_req && req;
        return v;
    endfunction

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_prog_mode",   32'(prog_mode),         32'(exp_in(M_PROG)));
            check("m_load_timer",  32'(load_timer),        32'(exp_in(M_LOAD)));
            check("m_run_enable",  32'(run_enable),        32'(exp_in(M_RUN)));
            check("m_enabled_led", 32'(enabled_led),       32'(exp_in(M_RUN)));
            check("m_running_led", 32'(running_led),       32'(exp_in(M_RUN) & {N_CH{m_flash}}));
            check("m_alarm_vec",   32'(alarm_vec),         32'(exp_alarm()));
            check("m_alarm_out",   32'(alarm_out),         32'((|exp_alarm()) & m_flash));
            check("m_inc_sec",     32'(increment_seconds), 32'(exp_inc(seconds_req)));
            check("m_inc_min",     32'(increment_minutes), 32'(exp_inc(minutes_req)));
            check("m_prog_onehot", 32'($countones(prog_mode) <= 1), 32'(1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prog"},  32'(prog_mode),   32'(0));
        check({tag, "_load"},  32'(load_timer),  32'(0));
        check({tag, "_run"},   32'(run_enable),  32'(0));
        check({tag, "_enled"}, 32'(enabled_led), 32'(0));
        check({tag, "_rnled"}, 32'(running_led), 32'(0));
        check({tag, "_alvec"}, 32'(alarm_vec),   32'(0));
        check({tag, "_alout"}, 32'(alarm_out),   32'(0));
        check({tag, "_incs"},  32'(increment_seconds), 32'(0));
    endtask

    initial begin
        reset_n      = 1'b0;
        led_pulse    = 1'b0;
        ch_sel       = '0;
        cooktime_req = 1'b0;
        start_req    = 1'b0;
        pause_req    = 1'b0;
        alarm_ack    = 1'b0;
        seconds_req  = 1'b0;
        minutes_req  = 1'b0;
        timer_done   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Program channel 1 and run it.
        ch_sel       = 2'd1;
        cooktime_req = 1'b1;
        #1 check("inc_idle", 32'(increment_seconds), 32'(0));
        tick();
        check("prog_ch1", 32'(prog_mode), 32'(2'b10));
        for (int k = 0; k < 3; k++) begin
            seconds_req = 1'b1;
            #1 check("inc_sec_ch1", 32'(increment_seconds), 32'(2'b10));
            check("inc_min_quiet", 32'(increment_minutes), 32'(0));
            tick();
            seconds_req = 1'b0;
        end
        cooktime_req = 1'b0;
        tick();
        check("prog_held", 32'(prog_mode), 32'(2'b10));
        seconds_req = 1'b1;
        #1 check("inc_no_cook", 32'(increment_seconds), 32'(0));
        seconds_req = 1'b0;
        start_req   = 1'b1;
        tick();
        start_req = 1'b0;
        check("load_ch1", 32'(load_timer), 32'(2'b10));
        check("load_norun", 32'(run_enable), 32'(0));
        tick();
        check("load_1cyc", 32'(load_timer), 32'(0));
        check("run_ch1", 32'(run_enable), 32'(2'b10));
        check("ch0_idle", 32'(prog_mode[0] | load_timer[0] | run_enable[0]), 32'(0));

        // Start channel 0, then pause and resume it.
        ch_sel    = 2'd0;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check("load_ch0", 32'(load_timer), 32'(2'b01));
        tick();
        check("run_both", 32'(run_enable), 32'(2'b11));
        pause_req = 1'b1;
        tick();
        pause_req = 1'b0;
        check("paused", 32'(run_enable), 32'(2'b10));
        check("pause_noload", 32'(load_timer), 32'(0));
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check("resumed", 32'(run_enable), 32'(2'b11));
        check("resume_noload", 32'(load_timer), 32'(0));

        // Channel 0 expires and flashes for ALARM_PULSES strobes.
        timer_done = 2'b01;
        tick();
        timer_done = '0;
        check("alarm_on", 32'(alarm_vec), 32'(2'b01));
        check("alarm_norun", 32'(run_enable), 32'(2'b10));
        check("alarm_out_dark", 32'(alarm_out), 32'(0));
        for (int k = 1; k <= 4; k++) begin
            led_pulse = 1'b1;
            tick();
            led_pulse = 1'b0;
            check("alarm_count", 32'(alarm_vec), (k < 4) ? 32'(2'b01) : 32'(0));
            check("alarm_out_flash", 32'(alarm_out), 32'((k < 4) && (k % 2 == 1)));
        end
        tick();
        check("alarm_quiet", 32'(alarm_vec), 32'(0));
        alarm_ack = 1'b1;
        tick();
        alarm_ack = 1'b0;

        // Expiry beats pause; in DONE, cooktime beats start.
        ch_sel     = 2'd1;
        pause_req  = 1'b1;
        timer_done = 2'b10;
        tick();
        pause_req  = 1'b0;
        timer_done = '0;
        check("prio_done", 32'(alarm_vec), 32'(2'b10));
        check("prio_norun", 32'(run_enable), 32'(0));
        cooktime_req = 1'b1;
        start_req    = 1'b1;
        tick();
        start_req = 1'b0;
        check("prio_prog", 32'(prog_mode), 32'(2'b10));
        check("prio_noload", 32'(load_timer), 32'(0));

        // Single editor: new programming channel evicts the old one.
        ch_sel = 2'd0;
        tick();
        check("editor_ch0", 32'(prog_mode), 32'(2'b01));
        ch_sel = 2'd1;
        tick();
        check("editor_ch1", 32'(prog_mode), 32'(2'b10));
        ch_sel = 2'd2;
        tick();
        check("editor_none", 32'(prog_mode), 32'(2'b10));
        cooktime_req = 1'b0;

        // Asynchronous reset in the middle of LOAD.
        ch_sel    = 2'd1;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check("preload", 32'(load_timer), 32'(2'b10));
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_noload", 32'(load_timer), 32'(0));
        check("post_reset_norun", 32'(run_enable), 32'(0));

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            ch_sel       = SEL_W'($urandom_range(0, 3));
            cooktime_req = ($urandom_range(0, 9) < 2);
            start_req    = ($urandom_range(0, 9) < 2);
            pause_req    = ($urandom_range(0, 9) < 2);
            alarm_ack    = ($urandom_range(0, 9) < 2);
            seconds_req  = ($urandom_range(0, 1) == 1);
            minutes_req  = ($urandom_range(0, 1) == 1);
            led_pulse    = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N_CH; i++) timer_done[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset_n = 1'b0;
                #1 check_all_zero("rand_reset");
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
